// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_pkg;

  // Controller state encoding; values are fixed for register-map compatibility.
  typedef enum logic [1:0] {
    UART_OFF  = 2'd0,
    UART_SYNC = 2'd1,
    UART_RUN  = 2'd2
  } uart_state_e;

  // Bit positions inside the {timeout,overflow,watermark} interrupt vector.
  localparam int unsigned INTR_WM  = 0;
  localparam int unsigned INTR_OVF = 1;
  localparam int unsigned INTR_TO  = 2;

  // Divisor loaded at reset, before the register file has programmed one.
  localparam logic [15:0] UART_RST_DIVISOR = 16'd87;

  // True on the last clock of a bit-time. Divisors of 0 and 1 tick every clock.
  function automatic logic bit_tick(input logic [15:0] cnt, input logic [15:0] div);
    return ({1'b0, cnt} + 17'd1) >= {1'b0, div};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO holding received characters until the bus reads them.
// Head data is combinational; flush beats push and pop in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PW         = $clog2(FIFO_DEPTH),
  parameter int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          i_Clock,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign level_o = level_q;

  // A pop frees a slot in the same cycle, so push into a full FIFO is legal alongside it.
  assign do_pop     = pop_i && !empty_o && !flush_i;
  assign do_push    = push_i && (!full_o || (pop_i && !empty_o)) && !flush_i;
  assign overflow_o = push_i && full_o && !pop_i && !flush_i;

  assign data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: divisor ownership, start-up line sync, RX FIFO gating
// and watermark/overflow/timeout interrupt generation.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TIMEOUT_BITS = 32,
  parameter int unsigned SYNC_BITS    = 10,
  parameter logic [15:0] RST_DIVISOR  = UART_RST_DIVISOR,
  parameter int unsigned L            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic         i_Clock,
  input  logic         rst_ni,
  input  logic         i_en,
  input  logic         i_flush,
  input  logic [15:0]  i_clks_per_bit,
  input  logic         i_rx_serial,
  input  logic         i_rx_dv,
  input  logic [7:0]   i_rx_byte,
  input  logic         i_rd_req,
  input  logic [L-1:0] i_watermark,
  input  logic [2:0]   i_intr_clr,
  output logic [15:0]  o_clks_per_bit,
  output logic [7:0]   o_rd_data,
  output logic [L-1:0] o_level,
  output logic         o_empty,
  output logic         o_full,
  output logic [2:0]   o_intr
);

  localparam logic [1:0] StOff  = UART_OFF;
  localparam logic [1:0] StSync = UART_SYNC;
  localparam logic [1:0] StRun  = UART_RUN;

  localparam int unsigned SW = $clog2(SYNC_BITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);

  logic          rx_meta_q, rx_sync_q;
  logic [1:0]    state_q, state_d;
  logic [15:0]   cpb_q;
  logic [15:0]   clk_cnt_q, clk_cnt_d;
  logic          tick;
  logic [SW-1:0] sync_cnt_q, sync_cnt_d;
  logic          sync_done;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_active, to_clear, to_set;
  logic          push_req, pop_ok;
  logic          fifo_empty, fifo_full, fifo_ovf;
  logic [L-1:0]  fifo_level;
  logic          wm_d;
  logic [2:0]    intr_q;
  logic          unused_wm_clr;

  // Watermark is level-type, so its clear bit has no effect.
  assign unused_wm_clr = i_intr_clr[INTR_WM];

  assign push_req = i_rx_dv && (state_q == StRun);
  assign pop_ok   = i_rd_req && !fifo_empty;

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .rst_ni     (rst_ni),
    .flush_i    (i_flush),
    .push_i     (push_req),
    .pop_i      (i_rd_req),
    .data_i     (i_rx_byte),
    .data_o     (o_rd_data),
    .level_o    (fifo_level),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .overflow_o (fifo_ovf)
  );

  assign o_level        = fifo_level;
  assign o_empty        = fifo_empty;
  assign o_full         = fifo_full;
  assign o_clks_per_bit = cpb_q;
  assign o_intr         = intr_q;

  // Two-flop synchroniser on the raw line; idles high like the line itself.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx_serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Divisor follows the register file only while off, so a frame never sees it change.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) cpb_q <= RST_DIVISOR;
    else if (state_q == StOff) cpb_q <= i_clks_per_bit;
  end

  // Bit-time divider: free-running while synchronising or receiving, parked at 0 when off.
  always_comb begin
    tick      = (state_q != StOff) && bit_tick(clk_cnt_q, cpb_q);
    clk_cnt_d = clk_cnt_q + 16'd1;
    if (state_q == StOff || tick) clk_cnt_d = '0;
  end

  // Count consecutive high bit-times; any low sample restarts the run.
  always_comb begin
    sync_done  = tick && rx_sync_q && (sync_cnt_q == SW'(SYNC_BITS - 1));
    sync_cnt_d = sync_cnt_q;
    if (state_q != StSync || !rx_sync_q) sync_cnt_d = '0;
    else if (tick)                       sync_cnt_d = sync_cnt_q + SW'(1);
  end

  // Controller FSM: enable drops straight to OFF from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff:   if (i_en) state_d = StSync;
      StSync:  begin
        if (!i_en)          state_d = StOff;
        else if (sync_done) state_d = StRun;
      end
      StRun:   if (!i_en) state_d = StOff;
      default: state_d = StOff;
    endcase
  end

  // Control-path registers for divider, sync counter and FSM.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StOff;
      clk_cnt_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  // Idle timer: bit-times with data waiting and no traffic; saturates at the threshold.
  always_comb begin
    to_active = (state_q == StRun) && tick;
    to_clear  = push_req || pop_ok || i_flush || fifo_empty;
    to_set    = to_active && !to_clear && (to_cnt_q == TW'(TIMEOUT_BITS - 1));
    to_cnt_d  = to_cnt_q;
    if (to_clear)
      to_cnt_d = '0;
    else if (to_active && to_cnt_q != TW'(TIMEOUT_BITS))
      to_cnt_d = to_cnt_q + TW'(1);
  end

  // Timeout counter register.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end

  assign wm_d = (i_watermark != '0) && (fifo_level >= i_watermark);

  // Interrupt vector: watermark tracks level, the other two are sticky with set winning over clear.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_q <= '0;
    end else begin
      intr_q[INTR_WM]  <= wm_d;
      intr_q[INTR_OVF] <= fifo_ovf | (intr_q[INTR_OVF] & ~i_intr_clr[INTR_OVF]);
      intr_q[INTR_TO]  <= to_set   | (intr_q[INTR_TO]  & ~i_intr_clr[INTR_TO]);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with default parameters.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        i_en = 1'b0;
  logic        i_flush = 1'b0;
  logic [15:0] i_clks_per_bit = 16'd4;
  logic        i_rx_serial = 1'b0;
  logic        i_rx_dv = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_rd_req = 1'b0;
  logic [4:0]  i_watermark = 5'd0;
  logic [2:0]  i_intr_clr = 3'b000;
  logic [15:0] o_clks_per_bit;
  logic [7:0]  o_rd_data;
  logic [4:0]  o_level;
  logic        o_empty, o_full;
  logic [2:0]  o_intr;

  int total = 0;
  int bad = 0;

  uart_rx_ctrl dut (
    .i_Clock        (clk),
    .rst_ni         (rst_ni),
    .i_en           (i_en),
    .i_flush        (i_flush),
    .i_clks_per_bit (i_clks_per_bit),
    .i_rx_serial    (i_rx_serial),
    .i_rx_dv        (i_rx_dv),
    .i_rx_byte      (i_rx_byte),
    .i_rd_req       (i_rd_req),
    .i_watermark    (i_watermark),
    .i_intr_clr     (i_intr_clr),
    .o_clks_per_bit (o_clks_per_bit),
    .o_rd_data      (o_rd_data),
    .o_level        (o_level),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_intr         (o_intr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    i_rx_dv = 1'b1; i_rx_byte = b;
    @(posedge clk); #1;
    i_rx_dv = 1'b0;
  endtask

  task automatic pop_one();
    i_rd_req = 1'b1;
    @(posedge clk); #1;
    i_rd_req = 1'b0;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", o_level); end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", o_empty); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", o_full); end
    total++; if (o_intr !== 3'b000) begin bad++; $display("FAIL rst_intr got=%b exp=000", o_intr); end
    total++; if (o_rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%h exp=00", o_rd_data); end
    total++; if (o_clks_per_bit !== 16'd87) begin bad++; $display("FAIL rst_cpb got=%0d exp=87", o_clks_per_bit); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    total++; if (o_clks_per_bit !== 16'd4) begin bad++; $display("FAIL off_cpb_track got=%0d exp=4", o_clks_per_bit); end
  endtask

  // Line low at enable, raised just after the 5th tick (edge 20); first tick with
  // the line high is edge 24, so the 10th is edge 60 and RUN begins after it.
  task automatic test_sync();
    i_rx_serial = 1'b0;
    i_en = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    i_rx_serial = 1'b1;
    i_clks_per_bit = 16'd9;
    repeat (39) @(posedge clk);
    #1;
    i_rx_dv = 1'b1; i_rx_byte = 8'h11;
    @(posedge clk); #1;
    total++; if (o_level !== 5'd0) begin bad++; $display("FAIL sync_early_push got=%0d exp=0", o_level); end
    i_rx_byte = 8'h22;
    @(posedge clk); #1;
    i_rx_dv = 1'b0;
    total++; if (o_level !== 5'd1) begin bad++; $display("FAIL sync_run_push got=%0d exp=1", o_level); end
    total++; if (o_rd_data !== 8'h22) begin bad++; $display("FAIL sync_run_data got=%h exp=22", o_rd_data); end
    total++; if (o_clks_per_bit !== 16'd4) begin bad++; $display("FAIL cpb_frozen got=%0d exp=4", o_clks_per_bit); end
    i_clks_per_bit = 16'd4;
    do_flush();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_fifo_order();
    push_byte(8'hA5);
    push_byte(8'h3C);
    total++; if (o_level !== 5'd2) begin bad++; $display("FAIL order_level2 got=%0d exp=2", o_level); end
    total++; if (o_rd_data !== 8'hA5) begin bad++; $display("FAIL order_head0 got=%h exp=a5", o_rd_data); end
    pop_one();
    total++; if (o_level !== 5'd1) begin bad++; $display("FAIL order_level1 got=%0d exp=1", o_level); end
    total++; if (o_rd_data !== 8'h3C) begin bad++; $display("FAIL order_head1 got=%h exp=3c", o_rd_data); end
    pop_one();
    total++; if (o_level !== 5'd0) begin bad++; $display("FAIL order_level0 got=%0d exp=0", o_level); end
    total++; if (o_rd_data !== 8'h00) begin bad++; $display("FAIL order_empty_data got=%h exp=00", o_rd_data); end
    pop_one();
    total++; if (o_level !== 5'd0 || o_intr[1] !== 1'b0) begin bad++; $display("FAIL pop_when_empty level=%0d ovf=%b exp 0/0", o_level, o_intr[1]); end
  endtask

  task automatic test_overflow();
    i_rx_dv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_rx_byte = 8'h40 + 8'(i);
      @(posedge clk); #1;
    end
    i_rx_dv = 1'b0;
    total++; if (o_full !== 1'b1 || o_level !== 5'd16) begin bad++; $display("FAIL full16 full=%b level=%0d exp 1/16", o_full, o_level); end
    total++; if (o_intr[1] !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", o_intr[1]); end
    push_byte(8'hEE);
    total++; if (o_intr[1] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", o_intr[1]); end
    total++; if (o_level !== 5'd16 || o_rd_data !== 8'h40) begin bad++; $display("FAIL ovf_drop level=%0d head=%h exp 16/40", o_level, o_rd_data); end
    i_intr_clr = 3'b010;
    @(posedge clk); #1;
    i_intr_clr = 3'b000;
    total++; if (o_intr[1] !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", o_intr[1]); end
    i_rx_dv = 1'b1; i_rx_byte = 8'h77; i_rd_req = 1'b1;
    @(posedge clk); #1;
    i_rx_dv = 1'b0; i_rd_req = 1'b0;
    total++; if (o_level !== 5'd16 || o_rd_data !== 8'h41) begin bad++; $display("FAIL full_pushpop level=%0d head=%h exp 16/41", o_level, o_rd_data); end
    total++; if (o_intr[1] !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b exp=0", o_intr[1]); end
    i_rx_dv = 1'b1; i_intr_clr = 3'b010;
    @(posedge clk); #1;
    i_rx_dv = 1'b0; i_intr_clr = 3'b000;
    total++; if (o_intr[1] !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", o_intr[1]); end
    i_flush = 1'b1; i_rx_dv = 1'b1; i_rx_byte = 8'h55;
    @(posedge clk); #1;
    i_flush = 1'b0; i_rx_dv = 1'b0;
    total++; if (o_level !== 5'd0 || o_empty !== 1'b1) begin bad++; $display("FAIL flush_push level=%0d empty=%b exp 0/1", o_level, o_empty); end
    total++; if (o_intr[1] !== 1'b1) begin bad++; $display("FAIL flush_keeps_intr got=%b exp=1", o_intr[1]); end
    i_intr_clr = 3'b010;
    @(posedge clk); #1;
    i_intr_clr = 3'b000;
  endtask

  task automatic test_watermark();
    i_watermark = 5'd4;
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    total++; if (o_level !== 5'd4 || o_intr[0] !== 1'b0) begin bad++; $display("FAIL wm_latency level=%0d wm=%b exp 4/0", o_level, o_intr[0]); end
    @(posedge clk); #1;
    total++; if (o_intr[0] !== 1'b1) begin bad++; $display("FAIL wm_set got=%b exp=1", o_intr[0]); end
    i_intr_clr = 3'b001;
    @(posedge clk); #1;
    i_intr_clr = 3'b000;
    total++; if (o_intr[0] !== 1'b1) begin bad++; $display("FAIL wm_clr_ignored got=%b exp=1", o_intr[0]); end
    pop_one();
    total++; if (o_level !== 5'd3 || o_intr[0] !== 1'b1) begin bad++; $display("FAIL wm_pop_lat level=%0d wm=%b exp 3/1", o_level, o_intr[0]); end
    @(posedge clk); #1;
    total++; if (o_intr[0] !== 1'b0) begin bad++; $display("FAIL wm_drop got=%b exp=0", o_intr[0]); end
    i_watermark = 5'd0;
    do_flush();
  endtask

  task automatic test_timeout();
    i_intr_clr = 3'b110;
    @(posedge clk); #1;
    i_intr_clr = 3'b000;
    push_byte(8'hC3);
    repeat (119) @(posedge clk);
    #1;
    total++; if (o_intr[2] !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", o_intr[2]); end
    repeat (13) @(posedge clk);
    #1;
    total++; if (o_intr[2] !== 1'b1) begin bad++; $display("FAIL to_set got=%b exp=1", o_intr[2]); end
    i_intr_clr = 3'b100;
    @(posedge clk); #1;
    i_intr_clr = 3'b000;
    repeat (20) @(posedge clk);
    #1;
    total++; if (o_intr[2] !== 1'b0) begin bad++; $display("FAIL to_clear_sat got=%b exp=0", o_intr[2]); end
    pop_one();
    push_byte(8'hD1);
    push_byte(8'hD2);
    repeat (100) @(posedge clk);
    #1;
    pop_one();
    repeat (100) @(posedge clk);
    #1;
    total++; if (o_intr[2] !== 1'b0) begin bad++; $display("FAIL to_pop_restart got=%b exp=0", o_intr[2]); end
    repeat (32) @(posedge clk);
    #1;
    total++; if (o_intr[2] !== 1'b1) begin bad++; $display("FAIL to_after_pop got=%b exp=1", o_intr[2]); end
    do_flush();
    i_intr_clr = 3'b100;
    @(posedge clk); #1;
    i_intr_clr = 3'b000;
  endtask

  task automatic test_disable();
    push_byte(8'h5A);
    push_byte(8'h6B);
    i_en = 1'b0;
    @(posedge clk); #1;
    push_byte(8'h99);
    total++; if (o_level !== 5'd2 || o_intr[1] !== 1'b0) begin bad++; $display("FAIL off_push_drop level=%0d ovf=%b exp 2/0", o_level, o_intr[1]); end
    i_clks_per_bit = 16'd6;
    @(posedge clk); #1;
    total++; if (o_clks_per_bit !== 16'd6) begin bad++; $display("FAIL off_cpb got=%0d exp=6", o_clks_per_bit); end
    total++; if (o_rd_data !== 8'h5A) begin bad++; $display("FAIL off_head got=%h exp=5a", o_rd_data); end
    pop_one();
    total++; if (o_level !== 5'd1 || o_rd_data !== 8'h6B) begin bad++; $display("FAIL off_pop level=%0d head=%h exp 1/6b", o_level, o_rd_data); end
  endtask

  task automatic test_reset_midframe();
    i_en = 1'b1;
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    total++; if (o_level !== 5'd0 || o_empty !== 1'b1) begin bad++; $display("FAIL arst_fifo level=%0d empty=%b exp 0/1", o_level, o_empty); end
    total++; if (o_rd_data !== 8'h00 || o_clks_per_bit !== 16'd87) begin bad++; $display("FAIL arst_out data=%h cpb=%0d exp 00/87", o_rd_data, o_clks_per_bit); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    i_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync();
    test_fifo_order();
    test_overflow();
    test_watermark();
    test_timeout();
    test_disable();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
